// File: rtl/uart_tx_frame_mux.sv
// UART transmit frame sequencer: one-word holding register, start/data/parity/stop
// framing, break generation and back-to-back frames, one bit per baud_tick.
module uart_tx_frame_mux #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  par_en,
    input  logic                  par_odd,
    input  logic                  stop2,
    input  logic                  brk,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                  state_reg, state_next;
    logic                    tx_reg, tx_next;
    logic [3:0]              bit_cnt_reg, bit_cnt_next;
    logic                    stop_cnt_reg, stop_cnt_next;
    logic [DATA_WIDTH-1:0]   hold_reg;
    logic                    hold_full_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    par_en_reg, par_odd_reg, stop2_reg;
    logic                    start_frame;
    logic                    last_stop;

    // n-th transmitted data bit; shifting avoids an index wider than the word
    function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] word, input logic [3:0] n);
        logic [DATA_WIDTH-1:0] shifted;
        shifted = word >> (MSB_FIRST ? (LAST_BIT - n) : n);
        return shifted[0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            tx_reg        <= 1'b1;
            bit_cnt_reg   <= '0;
            stop_cnt_reg  <= 1'b0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            data_reg      <= '0;
            par_en_reg    <= 1'b0;
            par_odd_reg   <= 1'b0;
            stop2_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_reg       <= tx_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            if (in_valid && !hold_full_reg) begin
                hold_reg      <= in_data;
                hold_full_reg <= 1'b1;
            end else if (start_frame) begin
                hold_full_reg <= 1'b0;
            end
            // Frame configuration is frozen for the whole frame
            if (start_frame) begin
                data_reg    <= hold_reg;
                par_en_reg  <= par_en;
                par_odd_reg <= par_odd;
                stop2_reg   <= stop2;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        tx_next       = tx_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        start_frame   = 1'b0;
        last_stop     = 1'b0;
        if (baud_tick) begin
            case (state_reg)
                S_IDLE: begin
                    if (brk) begin
                        state_next = S_BREAK;
                        tx_next    = 1'b0;
                    end else if (hold_full_reg) begin
                        start_frame = 1'b1;
                        state_next  = S_START;
                        tx_next     = 1'b0;
                    end else begin
                        tx_next = 1'b1;
                    end
                end
                S_START: begin
                    state_next   = S_DATA;
                    tx_next      = pick_bit(data_reg, 4'd0);
                    bit_cnt_next = '0;
                end
                S_DATA: begin
                    if (bit_cnt_reg < LAST_BIT) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        tx_next      = pick_bit(data_reg, bit_cnt_reg + 4'd1);
                    end else if (par_en_reg) begin
                        state_next = S_PARITY;
                        tx_next    = (^data_reg) ^ par_odd_reg;
                    end else begin
                        state_next    = S_STOP;
                        tx_next       = 1'b1;
                        stop_cnt_next = 1'b0;
                    end
                end
                S_PARITY: begin
                    state_next    = S_STOP;
                    tx_next       = 1'b1;
                    stop_cnt_next = 1'b0;
                end
                S_STOP: begin
                    if (stop2_reg && !stop_cnt_reg) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        last_stop = 1'b1;
                        // Pending word wins over idle, but a break request wins over both
                        if (hold_full_reg && !brk) begin
                            start_frame = 1'b1;
                            state_next  = S_START;
                            tx_next     = 1'b0;
                        end else if (brk) begin
                            state_next = S_BREAK;
                            tx_next    = 1'b0;
                        end else begin
                            state_next = S_IDLE;
                            tx_next    = 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (!brk) begin
                        state_next = S_IDLE;
                        tx_next    = 1'b1;
                    end else begin
                        tx_next = 1'b0;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    tx_next    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        tx_out     = tx_reg;
        in_ready   = !hold_full_reg;
        busy       = (state_reg != S_IDLE);
        frame_done = last_stop;
        state_o    = state_reg;
    end

endmodule

// File: tb/tb_uart_tx_frame_mux.sv
// Directed bench for uart_tx_frame_mux: an 8-bit LSB-first instance and a
// 7-bit MSB-first instance, with line bits recorded tick by tick.
module tb_uart_tx_frame_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_tick = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       par_en = 1'b0, par_odd = 1'b0, stop2 = 1'b0, brk = 1'b0;
    logic       tx_out, busy, frame_done;
    logic [2:0] state_o;

    logic [6:0] in_data7 = '0;
    logic       in_valid7 = 1'b0;
    logic       in_ready7, tx_out7, busy7, frame_done7;
    logic [2:0] state_o7;

    int          n_vec = 0;
    int          n_miss = 0;
    int          gap = 3;
    logic [31:0] bits, fds, bits7, fds7;

    uart_tx_frame_mux #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .par_en(par_en), .par_odd(par_odd), .stop2(stop2), .brk(brk),
        .tx_out(tx_out), .busy(busy), .frame_done(frame_done), .state_o(state_o)
    );

    uart_tx_frame_mux #(.DATA_WIDTH(7), .MSB_FIRST(1'b1)) dut7 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .in_data(in_data7), .in_valid(in_valid7), .in_ready(in_ready7),
        .par_en(par_en), .par_odd(par_odd), .stop2(stop2), .brk(brk),
        .tx_out(tx_out7), .busy(busy7), .frame_done(frame_done7), .state_o(state_o7)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        bits = '0; fds = '0; bits7 = '0; fds7 = '0;
    endtask

    // One tick per call; frame_done is sampled while the tick is high, the line after the edge.
    // Each recorder shifts left so a literal reads in time order.
    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            baud_tick = 1'b1;
            #1;
            fds  = {fds[30:0], frame_done};
            fds7 = {fds7[30:0], frame_done7};
            @(posedge clk);
            #1;
            baud_tick = 1'b0;
            bits  = {bits[30:0], tx_out};
            bits7 = {bits7[30:0], tx_out7};
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic load(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, tx_out}, 32'd1);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_state", {29'd0, state_o}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        chk("rst_ready7", {30'd0, in_ready7, busy7}, 32'd2);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8N1 0xA5
        clear_rec();
        load(8'hA5);
        chk("a5_ready_low", {31'd0, in_ready}, 32'd0);
        send(1);
        chk("a5_state_start", {29'd0, state_o}, 32'd1);
        send(10);
        chk("a5_bits", bits, 32'b01010010111);
        chk("a5_fd", fds, 32'b00000000001);
        chk("a5_end_state", {29'd0, state_o}, 32'd0);
        chk("a5_end_ready_busy", {30'd0, in_ready, busy}, 32'b10);

        // Even and odd parity on 0xA5
        par_en = 1'b1; par_odd = 1'b0;
        clear_rec();
        load(8'hA5);
        send(12);
        chk("a5_even_bits", bits, 32'b010100101011);
        chk("a5_even_fd", fds, 32'b000000000001);
        par_odd = 1'b1;
        clear_rec();
        load(8'hA5);
        send(12);
        chk("a5_odd_bits", bits, 32'b010100101111);

        // 0x07 even parity, two stops; config changed mid-frame must not apply
        par_odd = 1'b0; stop2 = 1'b1;
        clear_rec();
        load(8'h07);
        send(3);
        par_en = 1'b0; stop2 = 1'b0; par_odd = 1'b1;
        send(10);
        chk("07_bits", bits, 32'b0111000001111);
        chk("07_fd", fds, 32'b0000000000001);
        par_odd = 1'b0;

        // Back-to-back 0x55 then 0x0F
        clear_rec();
        load(8'h55);
        chk("b2b_ready0", {31'd0, in_ready}, 32'd0);
        send(1);
        chk("b2b_ready1", {31'd0, in_ready}, 32'd1);
        load(8'h0F);
        chk("b2b_ready2", {31'd0, in_ready}, 32'd0);
        send(10);
        chk("b2b_second_start", {28'd0, in_ready, state_o}, 32'b1001);
        send(10);
        chk("b2b_bits", bits, 32'b010101010101111000011);
        chk("b2b_fd", fds, 32'b000000000010000000001);

        // Continuous tick, one bit per clk
        gap = 0;
        clear_rec();
        load(8'hA5);
        send(11);
        chk("cont_bits", bits, 32'b01010010111);
        chk("cont_fd", fds, 32'b00000000001);
        gap = 3;

        // Break from IDLE, with a word loaded during the break
        brk = 1'b1;
        send(1);
        chk("brk_enter", {28'd0, tx_out, state_o}, 32'b0101);
        load(8'h33);
        chk("brk_load", {31'd0, in_ready}, 32'd0);
        send(2);
        chk("brk_hold", {28'd0, tx_out, state_o}, 32'b0101);
        brk = 1'b0;
        send(1);
        chk("brk_exit", {28'd0, tx_out, state_o}, 32'b1000);
        clear_rec();
        send(11);
        chk("after_brk_bits", bits, 32'b01100110011);

        // Break requested mid-frame: frame completes, then BREAK
        clear_rec();
        load(8'h5A);
        send(3);
        brk = 1'b1;
        send(8);
        chk("midbrk_bits", bits, 32'b00101101010);
        chk("midbrk_fd", fds, 32'b00000000001);
        chk("midbrk_state", {29'd0, state_o}, 32'd5);
        brk = 1'b0;
        send(1);
        chk("midbrk_exit", {28'd0, tx_out, state_o}, 32'b1000);

        // Asynchronous reset during DATA
        load(8'h00);
        send(4);
        chk("pre_rst_data", {28'd0, tx_out, state_o}, 32'b0010);
        load(8'h12);
        chk("pre_rst_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("async_rst", {26'd0, tx_out, in_ready, busy, state_o}, 32'b110000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_rec();
        load(8'hA5);
        send(11);
        chk("post_rst_bits", bits, 32'b01010010111);

        // 7-bit MSB-first instance: 0x41
        clear_rec();
        in_data7  = 7'h41;
        in_valid7 = 1'b1;
        @(posedge clk);
        #1;
        in_valid7 = 1'b0;
        send(10);
        chk("msb7_bits", bits7, 32'b0100000111);
        chk("msb7_fd", fds7, 32'b0000000001);
        chk("msb7_end", {29'd0, state_o7}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_mux.md
Name: uart_tx_frame_mux

Overview:
Parametrised UART transmit frame sequencer and line driver, one per TX channel, between the TX data source and the serial pin. Takes a parallel word over a valid/ready handshake and buffers one word in a holding register. Drives start, data, optional parity and 1 or 2 stop bits onto a registered tx_out, with one bit per baud_tick period. Adds break generation, runtime parity/stop configuration, bit-order selection and back-to-back framing with no idle gap.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
MSB_FIRST, 0, 0 = LSB sent first, 1 = MSB sent first.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
baud_tick  input  1  one-clk strobe, one per bit period
in_data  input  DATA_WIDTH  word to transmit
in_valid  input  1  in_data valid
in_ready  output  1  holding register empty; word accepted when in_valid & in_ready
par_en  input  1  1 = insert parity bit
par_odd  input  1  0 = even parity, 1 = odd parity
stop2  input  1  0 = one stop bit, 1 = two stop bits
brk  input  1  request line break (hold tx_out low)
tx_out  output  1  serial line, registered, idle high
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-clk pulse on the tick that ends the last stop bit
state_o  output  3  current bit type: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5

Behaviour:
- Reset (rst=0, async): tx_out=1, state IDLE, hold empty (in_ready=1), busy=0, frame_done=0, bit and stop counters 0. Reset mid-frame aborts the frame and the line returns high immediately.
- Holding register: a word is loaded on any clk with in_valid & in_ready, in any state. in_ready = !hold_full. It is emptied on the tick that moves the word into the shift register (frame start). A load and an empty never coincide on the same clk, because in_ready=0 while hold_full.
- State and tx_out change only on clk edges where baud_tick=1, except for reset.
- IDLE, on a tick, evaluated in priority order:
  - brk=1: go to BREAK, tx_out<=0.
  - else hold_full: frame start. Go to START, tx_out<=0, copy the hold word to the shift register, empty the hold, and latch par_en, par_odd and stop2 for the whole frame.
  - else: stay in IDLE, tx_out=1.
- START, tick: go to DATA, tx_out<=first data bit (bit 0, or bit DATA_WIDTH-1 if MSB_FIRST), bit_cnt<=0.
- DATA, tick:
  - if bit_cnt<DATA_WIDTH-1: bit_cnt++ and output the next bit.
  - else if the latched par_en is set: go to PARITY, tx_out <= XOR of all data bits, XOR the latched par_odd.
  - else: go to STOP, tx_out<=1, stop_cnt<=0.
- PARITY, tick: go to STOP, tx_out<=1, stop_cnt<=0.
- STOP, tick:
  - stop2 latched and stop_cnt==0: stop_cnt<=1, stay in STOP.
  - otherwise this tick ends the last stop bit: frame_done=1 for this clk, then:
    - if hold_full and brk=0: back-to-back frame start, same actions as the IDLE frame start (START, tx_out<=0). There is no idle bit between frames.
    - else if brk=1: go to BREAK, tx_out<=0.
    - else: go to IDLE, tx_out=1.
- BREAK: tx_out=0. On a tick with brk=0, go to IDLE and set tx_out<=1; at least one idle bit always follows a break. brk never interrupts a frame already in progress; it is sampled only in IDLE or at the end of STOP. The holding register still accepts data during BREAK.
- Frame length in ticks: 1 + DATA_WIDTH + par_en + (1 + stop2).
- Changes to par_en, par_odd or stop2 in mid-frame have no effect until the next frame start.
- If baud_tick is held high continuously, one bit is sent per clk; this must still work.

Test Plan:
- Basic frame: 8N1, load 0xA5 in IDLE, ticks every 16 clk -> tx_out on successive ticks reads 0,1,0,1,0,0,1,0,1,1. frame_done pulses on tick 10, then IDLE and in_ready=1.
- Parity: 0xA5 with par_en=1 -> parity bit 0 when par_odd=0 and 1 when par_odd=1. 0x07 with even parity -> parity bit 1. With stop2=1 -> two high stop ticks, and frame_done on tick 12.
- Back-to-back: load 0x55, then load 0x0F during the first frame (in_ready drops to 0) -> the start bit of 0x0F follows the last stop tick with no idle tick between, and in_ready=1 after the second frame start.
- MSB_FIRST=1, DATA_WIDTH=7: send 0x41 -> data bits 1,0,0,0,0,0,1. Frame is 9 ticks with no parity and one stop bit.
- Break: assert brk in IDLE -> tx_out=0 from the next tick and state_o=5. Deassert brk -> tx_out=1 at the following tick. Assert brk mid-frame -> the frame completes intact, then BREAK.
- Reset mid-frame: drop rst during DATA -> tx_out=1 asynchronously, in_ready=1, state_o=0, and a new frame then runs cleanly.
